// File: rtl/mips_multiciclo_ctrl.sv
// rtl/mips_multiciclo_ctrl.sv - multi-cycle MIPS control sequencer
//
// Steps each instruction through FETCH/DECODE/EXEC/MEM/MUL/WB. Drives the
// datapath strobes and the memory and multiplier handshakes, and counts
// retired instructions. Reads the held IR word and sits beside the
// combinational control decoder.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   instrucao[31:0]     IR contents, stable from DECODE through WB
//   mem_ack             memory completion (meaningful while mem_req=1)
//   mul_done            multiplier completion (meaningful in MUL)
//   pc_we, ir_we        PC <- PC+4 and IR load, on the FETCH acknowledge
//   mem_req, mem_we     memory request (held until ack), 1=write
//   mem_sel_addr        memory address source: 0=PC, 1=ALU result
//   alu_op[2:0]         000=ADD, 001=SUB
//   alu_src_b           0=rt, 1=sign-extended imm16
//   mul_start           one-cycle multiplier start
//   reg_we, reg_dst     register write enable, destination 0=rt 1=rd
//   wb_sel[1:0]         write-back source 00=ALU 01=MEM 10=MUL
//   estado[2:0]         current state code
//   err_code[1:0]       00 none, 01 illegal, 10 mem timeout, 11 mul timeout
//   instr_count         retired instructions, wraps
module mips_multiciclo_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instrucao,
    input  logic             mem_ack,
    input  logic             mul_done,
    output logic             pc_we,
    output logic             ir_we,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_sel_addr,
    output logic [2:0]       alu_op,
    output logic             alu_src_b,
    output logic             mul_start,
    output logic             reg_we,
    output logic             reg_dst,
    output logic [1:0]       wb_sel,
    output logic [2:0]       estado,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_MUL    = 3'd4,
        S_WB     = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    localparam logic [5:0] OP_MUL = 6'b000100;
    localparam logic [5:0] OP_LW  = 6'b000101;
    localparam logic [5:0] OP_SW  = 6'b000110;
    localparam logic [5:0] OP_ALU = 6'b001110;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_MUL = 6'b110010;

    // Counter holds 0..TIMEOUT-1: the value is the index of the current
    // cycle inside a wait state.
    localparam int WC_W = $clog2(TIMEOUT);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

    state_t          state;
    state_t          state_nxt;
    logic [WC_W-1:0] wait_cnt;
    logic [1:0]      err_nxt;
    logic            retire;
    logic            at_limit;

    logic [5:0] op;
    logic [5:0] funct;
    logic       is_lw;
    logic       is_sw;
    logic       is_mul;
    logic       is_alu;
    logic       is_sub;
    logic       legal;
    logic       unused_ir;

    assign op        = instrucao[31:26];
    assign funct     = instrucao[5:0];
    assign unused_ir = ^instrucao[25:6];

    assign is_lw  = (op == OP_LW);
    assign is_sw  = (op == OP_SW);
    assign is_mul = (op == OP_MUL) && (funct == FN_MUL);
    assign is_alu = (op == OP_ALU) && ((funct == FN_ADD) || (funct == FN_SUB));
    assign is_sub = (funct == FN_SUB);
    assign legal  = is_lw || is_sw || is_mul || is_alu;

    // Last permitted cycle of a wait state; an ack in this cycle still wins.
    assign at_limit = (wait_cnt == WC_LAST);

    assign estado = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_FETCH;
            wait_cnt    <= '0;
            err_code    <= 2'b00;
            instr_count <= '0;
        end else begin
            state    <= state_nxt;
            err_code <= err_nxt;
            if (state_nxt != state) begin
                wait_cnt <= '0;
            end else if (state != S_ERROR) begin
                wait_cnt <= wait_cnt + WC_W'(1);
            end
            if (retire) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        err_nxt   = err_code;
        retire    = 1'b0;
        case (state)
            S_FETCH: begin
                if (mem_ack) begin
                    state_nxt = S_DECODE;
                end else if (at_limit) begin
                    state_nxt = S_ERROR;
                    err_nxt   = 2'b10;
                end
            end
            S_DECODE: begin
                if (legal) begin
                    state_nxt = S_EXEC;
                end else begin
                    state_nxt = S_ERROR;
                    err_nxt   = 2'b01;
                end
            end
            S_EXEC: begin
                if (is_lw || is_sw) begin
                    state_nxt = S_MEM;
                end else if (is_mul) begin
                    state_nxt = S_MUL;
                end else begin
                    state_nxt = S_WB;
                end
            end
            S_MEM: begin
                if (mem_ack) begin
                    if (is_sw) begin
                        state_nxt = S_FETCH;
                        retire    = 1'b1;
                    end else begin
                        state_nxt = S_WB;
                    end
                end else if (at_limit) begin
                    state_nxt = S_ERROR;
                    err_nxt   = 2'b10;
                end
            end
            S_MUL: begin
                if (mul_done) begin
                    state_nxt = S_WB;
                end else if (at_limit) begin
                    state_nxt = S_ERROR;
                    err_nxt   = 2'b11;
                end
            end
            S_WB: begin
                state_nxt = S_FETCH;
                retire    = 1'b1;
            end
            default: begin
                state_nxt = S_ERROR;
            end
        endcase
    end

    // Strobes are forced low while rst_n is asserted so that the reset
    // state (FETCH) does not present a request until reset is released.
    always_comb begin
        pc_we        = 1'b0;
        ir_we        = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_sel_addr = 1'b0;
        alu_op       = 3'b000;
        alu_src_b    = 1'b0;
        mul_start    = 1'b0;
        reg_we       = 1'b0;
        reg_dst      = 1'b0;
        wb_sel       = 2'b00;
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    ir_we   = mem_ack;
                    pc_we   = mem_ack;
                end
                S_EXEC: begin
                    if (is_lw || is_sw) begin
                        alu_src_b = 1'b1;
                    end else if (is_alu) begin
                        alu_op = is_sub ? 3'b001 : 3'b000;
                    end else if (is_mul) begin
                        mul_start = 1'b1;
                    end
                end
                S_MEM: begin
                    mem_req      = 1'b1;
                    mem_sel_addr = 1'b1;
                    mem_we       = is_sw;
                    alu_src_b    = 1'b1;
                end
                S_WB: begin
                    reg_we = 1'b1;
                    if (is_lw) begin
                        reg_dst = 1'b0;
                        wb_sel  = 2'b01;
                    end else if (is_mul) begin
                        reg_dst = 1'b1;
                        wb_sel  = 2'b10;
                    end else begin
                        reg_dst = 1'b1;
                        wb_sel  = 2'b00;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
